// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - command bit indices, power states and pin decode for ddr4_cmd_decoder
package ddr_cmd_pkg;

    localparam int NUM_CMDS = 19;

    localparam int CMD_ACT  = 18;
    localparam int CMD_BST  = 17;
    localparam int CMD_CFG  = 16;
    localparam int CMD_CKEH = 15;
    localparam int CMD_CKEL = 14;
    localparam int CMD_DPD  = 13;
    localparam int CMD_DPDX = 12;
    localparam int CMD_MRR  = 11;
    localparam int CMD_MRW  = 10;
    localparam int CMD_PD   = 9;
    localparam int CMD_PDX  = 8;
    localparam int CMD_PR   = 7;
    localparam int CMD_PRA  = 6;
    localparam int CMD_RD   = 5;
    localparam int CMD_RDA  = 4;
    localparam int CMD_REF  = 3;
    localparam int CMD_SRF  = 2;
    localparam int CMD_WR   = 1;
    localparam int CMD_WRA  = 0;

    typedef enum logic [1:0] {
        PWR_NORMAL    = 2'd0,
        PWR_POWERDOWN = 2'd1,
        PWR_SELFREF   = 2'd2
    } pwr_state_t;

    // rcw = {RAS_n, CAS_n, WE_n}; a10 selects auto-precharge / all-banks
    function automatic logic [NUM_CMDS-1:0] decode_pins(input logic act_n,
                                                        input logic [2:0] rcw,
                                                        input logic a10);
        logic [NUM_CMDS-1:0] cmd;
        cmd = '0;
        if (!act_n) begin
            cmd[CMD_ACT] = 1'b1;
        end else begin
            case (rcw)
                3'b000:  cmd[CMD_MRW] = 1'b1;
                3'b001:  cmd[CMD_REF] = 1'b1;
                3'b010:  cmd[a10 ? CMD_PRA : CMD_PR] = 1'b1;
                3'b100:  cmd[a10 ? CMD_WRA : CMD_WR] = 1'b1;
                3'b101:  cmd[a10 ? CMD_RDA : CMD_RD] = 1'b1;
                3'b110:  cmd[CMD_CFG] = 1'b1;
                default: cmd = '0;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ca_parity_checker.sv
// rtl/ca_parity_checker.sv - even parity check, alert_n pulse stretcher and saturating error count
module ca_parity_checker #(
    parameter int WIDTH    = 22,
    parameter int ALERT_PW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check_en,
    input  logic [WIDTH-1:0] pins,
    input  logic             par,
    output logic             par_err,
    output logic             alert_n,
    output logic [7:0]       par_errs
);

    localparam int CW = $clog2(ALERT_PW + 1);

    logic [CW-1:0] alert_cnt;

    assign par_err = check_en & (^{pins, par});

    // a fresh error reloads the counter so back-to-back errors extend the pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            alert_cnt <= '0;
            par_errs  <= '0;
        end else begin
            if (par_err)
                alert_cnt <= CW'(ALERT_PW);
            else if (alert_cnt != '0)
                alert_cnt <= alert_cnt - 1'b1;
            if (par_err && par_errs != 8'hFF)
                par_errs <= par_errs + 8'd1;
        end
    end

    assign alert_n = (alert_cnt == '0);

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// rtl/ddr4_cmd_decoder.sv - DDR4 pin decoder with CKE power FSM; CA_PARITY_EN adds parity checking
module ddr4_cmd_decoder
    import ddr_cmd_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int ALERT_PW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic [BGWIDTH-1:0]   bg_in,
    input  logic [BAWIDTH-1:0]   ba_in,
    input  logic [ADDRWIDTH-1:0] addr_in,
    input  logic                 par,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [ADDRWIDTH-1:0] addr,
    output logic [NUM_CMDS-1:0]  commands,
    output logic [1:0]           pwr_state,
    output logic                 alert_n,
    output logic [7:0]           par_errs
);

    pwr_state_t            state_q, state_d;
    logic                  cke_q;
    logic                  cke_fall, cke_rise;
    logic [2:0]            rcw;
    logic                  par_err;
    logic [NUM_CMDS-1:0]   cmd_d;

    assign rcw      = addr_in[ADDRWIDTH-1 -: 3];
    assign cke_fall = cke_q & ~cke;
    assign cke_rise = ~cke_q & cke;

    always_comb begin
        state_d = state_q;
        cmd_d   = '0;
        case (state_q)
            PWR_NORMAL: begin
                if (cke_fall) begin
                    // REF pins on the falling CKE edge mean self-refresh entry
                    if (!cs_n && {act_n, rcw} == 4'b1001) begin
                        state_d        = PWR_SELFREF;
                        cmd_d[CMD_SRF] = 1'b1;
                    end else begin
                        state_d        = PWR_POWERDOWN;
                        cmd_d[CMD_PD]  = 1'b1;
                    end
                    cmd_d[CMD_CKEL] = 1'b1;
                end else if (cke_q && cke && !cs_n && !par_err) begin
                    cmd_d = decode_pins(act_n, rcw, addr_in[10]);
                end
            end
            PWR_POWERDOWN: begin
                if (cke_rise) begin
                    state_d         = PWR_NORMAL;
                    cmd_d[CMD_PDX]  = 1'b1;
                    cmd_d[CMD_CKEH] = 1'b1;
                end
            end
            PWR_SELFREF: begin
                if (cke_rise) begin
                    state_d         = PWR_NORMAL;
                    cmd_d[CMD_CKEH] = 1'b1;
                end
            end
            default: state_d = PWR_NORMAL;
        endcase
        // LPDDR-only commands never occur on DDR4
        cmd_d[CMD_BST]  = 1'b0;
        cmd_d[CMD_DPD]  = 1'b0;
        cmd_d[CMD_DPDX] = 1'b0;
        cmd_d[CMD_MRR]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PWR_NORMAL;
            cke_q    <= 1'b1;
            commands <= '0;
            bg       <= '0;
            ba       <= '0;
            addr     <= '0;
        end else begin
            state_q  <= state_d;
            cke_q    <= cke;
            commands <= cmd_d;
            bg       <= bg_in;
            ba       <= ba_in;
            addr     <= addr_in;
        end
    end

    assign pwr_state = state_q;

`ifdef CA_PARITY_EN
    ca_parity_checker #(
        .WIDTH   (1 + BGWIDTH + BAWIDTH + ADDRWIDTH),
        .ALERT_PW(ALERT_PW)
    ) u_parity (
        .clk     (clk),
        .reset   (reset),
        .check_en(!cs_n && state_q == PWR_NORMAL),
        .pins    ({act_n, bg_in, ba_in, addr_in}),
        .par     (par),
        .par_err (par_err),
        .alert_n (alert_n),
        .par_errs(par_errs)
    );
`else
    localparam int unused_alert_pw = ALERT_PW;
    logic unused_par;
    assign unused_par = par;
    assign par_err    = 1'b0;
    assign alert_n    = 1'b1;
    assign par_errs   = 8'd0;
`endif

endmodule
